instr_prefetch: RTL and testbench

Instruction-fetch initiator that drives the single-port instruction RAM's request port and buffers returned words for the core. It generates sequential byte addresses, accounts for the RAM's fixed one-cycle read latency, and holds fetched words in a small FIFO. It presents them to the core with a valid/ready handshake and supports single-cycle branch redirection with flush.

---
 rtl/instr_prefetch.sv | 120 ++++++++++++
 tb/tb_instr_prefetch.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: sequential fetch with one-cycle RAM latency, DEPTH-entry FIFO, branch flush.
// Optional macro PREFETCH_BYPASS_EN presents a response arriving into an empty FIFO in the same cycle.

module instr_prefetch #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d, resp_addr_q, target;
    logic                    inflight_q, issue;
    logic [ADDR_WIDTH-1:0]   fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data [DEPTH];
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    fifo_empty, bypass, pop, fifo_pop, push, drop;

    assign target     = branch_addr_i & ~ADDR_WIDTH'(3);
    assign fifo_empty = (count_q == '0);
    // With a one-cycle RAM, the only response a branch can orphan is the one arriving right now.
    assign drop       = branch_i & inflight_q;

`ifdef PREFETCH_BYPASS_EN
    assign bypass        = fifo_empty & inflight_q;
    assign instr_rdata_o = bypass ? mem_rdata_i : fifo_data[rd_ptr_q];
    assign instr_addr_o  = bypass ? resp_addr_q : fifo_addr[rd_ptr_q];
`else
    assign bypass        = 1'b0;
    assign instr_rdata_o = fifo_data[rd_ptr_q];
    assign instr_addr_o  = fifo_addr[rd_ptr_q];
`endif

    assign instr_valid_o = ~fifo_empty | bypass;
    assign pop           = instr_valid_o & instr_ready_i & ~branch_i;
    assign fifo_pop      = pop & ~fifo_empty;
    assign push          = inflight_q & ~drop & ~(bypass & pop);
    assign count_d       = branch_i ? '0 : count_q + CW'(push) - CW'(fifo_pop);

    assign mem_en_o    = issue;
    assign mem_we_o    = 1'b0;
    assign mem_be_o    = '1;
    assign mem_wdata_o = '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue      = 1'b0;
        mem_addr_o = pc_q;
        case (state_q)
            IDLE: if (req_i)  state_d = RUN;
            RUN:  if (!req_i) state_d = IDLE;
        endcase
        if (branch_i) begin
            mem_addr_o = target;
            issue      = req_i;
            pc_d       = req_i ? target + ADDR_WIDTH'(4) : target;
        end else if (state_q == RUN &&
                     (int'(count_q) + int'(inflight_q)) < (int'(DEPTH) + int'(pop))) begin
            issue = 1'b1;
            pc_d  = pc_q + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= BOOT_ADDR;
            inflight_q  <= 1'b0;
            resp_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            count_q    <= count_d;
            if (issue) resp_addr_q <= mem_addr_o;
            if (branch_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_addr[wr_ptr_q] <= resp_addr_q;
                    fifo_data[wr_ptr_q] <= mem_rdata_i;
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                end
                if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios plus random traffic against a queue-based model.
// Honours PREFETCH_BYPASS_EN in the reference model and latency expectations.

module tb_instr_prefetch;

    localparam int          DEP  = 2;
    localparam logic [7:0]  BOOT = 8'h00;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_i, req_i, branch_i, instr_ready_i;
    logic [7:0]  branch_addr_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o, mem_en_o, mem_we_o;
    logic [31:0] instr_rdata_o, mem_wdata_o;
    logic [7:0]  instr_addr_o, mem_addr_o;
    logic [3:0]  mem_be_o;

    instr_prefetch #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEP), .BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ramf(input logic [7:0] a);
        logic [31:0] i;
        i = 32'(a >> 2);
        return 32'h13 | (i << 7) | (i << 20);
    endfunction

    always @(posedge clk) if (mem_en_o) mem_rdata_i <= ramf(mem_addr_o);

    int n_cmp = 0, n_err = 0, cyc_n = 0;

    // Reference model: fetch queue plus a single outstanding-read slot.
    bit          m_run, m_infl;
    logic [7:0]  m_pc, m_infl_addr;
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    bit          e_valid, e_en, e_pop;
    logic [7:0]  e_addr, e_maddr;
    logic [31:0] e_data;

    logic [7:0]  iss_q[$], acc_a[$];
    logic [31:0] acc_d[$];
    int          iss_c[$];
    int          first_iss, first_val;

    task automatic model_reset();
        m_run = 0; m_infl = 0; m_pc = BOOT; m_infl_addr = '0;
        q_addr.delete(); q_data.delete();
    endtask

    task automatic model_eval();
        int sz;
        sz = q_addr.size();
        e_valid = (sz > 0); e_addr = '0; e_data = '0;
        if (sz > 0) begin e_addr = q_addr[0]; e_data = q_data[0]; end
`ifdef PREFETCH_BYPASS_EN
        if (sz == 0 && m_infl) begin e_valid = 1; e_addr = m_infl_addr; e_data = ramf(m_infl_addr); end
`endif
        e_pop = e_valid && instr_ready_i && !branch_i;
        if (branch_i) begin
            e_en = req_i; e_maddr = branch_addr_i & 8'hFC;
        end else begin
            e_en = m_run && (sz + int'(m_infl) - int'(e_pop) < DEP); e_maddr = m_pc;
        end
    endtask

    task automatic model_update();
        int sz;
        logic [7:0] tgt;
        if (rst_i) begin model_reset(); return; end
        sz  = q_addr.size();
        tgt = branch_addr_i & 8'hFC;
        if (branch_i) begin
            q_addr.delete(); q_data.delete();
        end else begin
            if (sz > 0 && e_pop) begin void'(q_addr.pop_front()); void'(q_data.pop_front()); end
            if (m_infl && !(sz == 0 && e_pop)) begin
                q_addr.push_back(m_infl_addr); q_data.push_back(ramf(m_infl_addr));
            end
        end
        if (branch_i) m_pc = req_i ? tgt + 8'd4 : tgt;
        else if (e_en) m_pc = m_pc + 8'd4;
        m_infl = e_en; m_infl_addr = e_maddr; m_run = req_i;
    endtask

    task automatic clear_log();
        iss_q.delete(); iss_c.delete(); acc_a.delete(); acc_d.delete();
        first_iss = -1; first_val = -1;
    endtask

    task automatic set_in(input bit r, input bit b, input logic [7:0] ba, input bit rdy);
        req_i = r; branch_i = b; branch_addr_i = ba; instr_ready_i = rdy;
        #1;
        model_eval();
        if (mem_en_o) begin
            iss_q.push_back(mem_addr_o); iss_c.push_back(cyc_n);
            if (first_iss < 0) first_iss = cyc_n;
        end
        if (instr_valid_o && !b) begin
            if (first_val < 0) first_val = cyc_n;
            if (rdy) begin acc_a.push_back(instr_addr_o); acc_d.push_back(instr_rdata_o); end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit b, input logic [7:0] ba, input bit rdy);
        set_in(r, b, ba, rdy);
        tick();
    endtask

    task automatic do_reset();
        rst_i = 1;
        set_in(0, 0, 8'h00, 1);
        tick(); tick();
        rst_i = 0;
        clear_log();
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 8'h00, 1);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (mem_en_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en_o); end
        n_cmp++; if (mem_addr_o !== BOOT) begin n_err++; $display("FAIL reset_pc: got %h want %h", mem_addr_o, BOOT); end
        n_cmp++; if (instr_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", instr_rdata_o); end
        n_cmp++; if (instr_addr_o !== 8'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", instr_addr_o); end
        n_cmp++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
            n_err++; $display("FAIL reset_consts: got we=%b be=%h wd=%h want 0/f/0", mem_we_o, mem_be_o, mem_wdata_o);
        end
        tick();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= iss_q.size() || iss_q[i] !== 8'(4 * i)) begin
                n_err++; $display("FAIL stream_issue%0d: got %h want %h", i, (i < iss_q.size()) ? iss_q[i] : 8'hxx, 8'(4 * i));
            end
        end
        n_cmp++;
        if (iss_c.size() < 3 || iss_c[2] - iss_c[0] != 2) begin
            n_err++; $display("FAIL stream_consecutive: got %0d issues not back-to-back want 3 consecutive", iss_c.size());
        end
        n_cmp++;
        if (first_iss < 0 || first_val - first_iss != LAT) begin
            n_err++; $display("FAIL stream_latency: got %0d want %0d", first_val - first_iss, LAT);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= acc_a.size() || acc_a[i] !== 8'(4 * i) || acc_d[i] !== ramf(8'(4 * i))) begin
                n_err++; $display("FAIL stream_accept%0d: got %h/%h want %h/%h", i,
                    (i < acc_a.size()) ? acc_a[i] : 8'hxx, (i < acc_d.size()) ? acc_d[i] : 32'hx, 8'(4 * i), ramf(8'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 8'h00, 0);
            if (instr_valid_o) begin
                n_cmp++;
                if (instr_addr_o !== 8'h00 || instr_rdata_o !== 32'h13) begin
                    n_err++; $display("FAIL bp_head_stable: got %h/%h want 00/00000013", instr_addr_o, instr_rdata_o);
                end
            end
            tick();
        end
        n_cmp++; if (iss_q.size() != 2) begin n_err++; $display("FAIL bp_issue_count: got %0d want 2", iss_q.size()); end
        clear_log();
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, 1);
        n_cmp++;
        if (iss_q.size() == 0 || iss_q[0] !== 8'h08) begin
            n_err++; $display("FAIL bp_resume_addr: got %h want 08", (iss_q.size() > 0) ? iss_q[0] : 8'hxx);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= acc_a.size() || acc_a[i] !== 8'(4 * i)) begin
                n_err++; $display("FAIL bp_order%0d: got %h want %h", i, (i < acc_a.size()) ? acc_a[i] : 8'hxx, 8'(4 * i));
            end
        end
    endtask

    task automatic test_branch_flush();
        bit found;
        int bc;
        found = 0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            set_in(1, 0, 8'h00, 1);
            if (mem_en_o && mem_addr_o == 8'h0C) found = 1;
            tick();
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL flush_setup: got no issue of 0c want issue of 0c"); end
        clear_log();
        bc = cyc_n;
        set_in(1, 1, 8'h40, 1);
        n_cmp++; if (mem_en_o !== 1'b1 || mem_addr_o !== 8'h40) begin
            n_err++; $display("FAIL flush_issue: got en=%b addr=%h want 1/40", mem_en_o, mem_addr_o);
        end
        tick();
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1);
        n_cmp++; if (first_val - bc != LAT) begin n_err++; $display("FAIL flush_latency: got %0d want %0d", first_val - bc, LAT); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= acc_a.size() || acc_a[i] !== 8'(8'h40 + 4 * i) || acc_d[i] !== ramf(8'(8'h40 + 4 * i))) begin
                n_err++; $display("FAIL flush_stream%0d: got %h want %h", i, (i < acc_a.size()) ? acc_a[i] : 8'hxx, 8'(8'h40 + 4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hF8; exp_a[1] = 8'hFC; exp_a[2] = 8'h00;
        clear_log();
        cyc(1, 1, 8'hF8, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= iss_q.size() || iss_q[i] !== exp_a[i]) begin
                n_err++; $display("FAIL wrap_issue%0d: got %h want %h", i, (i < iss_q.size()) ? iss_q[i] : 8'hxx, exp_a[i]);
            end
            n_cmp++;
            if (i >= acc_a.size() || acc_a[i] !== exp_a[i]) begin
                n_err++; $display("FAIL wrap_accept%0d: got %h want %h", i, (i < acc_a.size()) ? acc_a[i] : 8'hxx, exp_a[i]);
            end
        end
    endtask

    task automatic test_branch_pop();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 1);
        clear_log();
        set_in(1, 1, 8'h23, 1);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL bpop_head_valid: got %b want 1", instr_valid_o); end
        n_cmp++; if (mem_addr_o !== 8'h20) begin n_err++; $display("FAIL bpop_align: got %h want 20", mem_addr_o); end
        tick();
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= acc_a.size() || acc_a[i] !== 8'(8'h20 + 4 * i)) begin
                n_err++; $display("FAIL bpop_stream%0d: got %h want %h", i, (i < acc_a.size()) ? acc_a[i] : 8'hxx, 8'(8'h20 + 4 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h00, 0);
        set_in(1, 0, 8'h00, 1);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_full: got %b want 1", instr_valid_o); end
        rst_i = 1;
        tick();
        rst_i = 0;
        set_in(0, 0, 8'h00, 1);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (mem_addr_o !== BOOT || mem_en_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_pc: got en=%b addr=%h want 0/%h", mem_en_o, mem_addr_o, BOOT);
        end
        tick();
        set_in(0, 0, 8'h00, 1);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got %b want 0", instr_valid_o); end
        tick();
        clear_log();
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 1);
        n_cmp++;
        if (acc_a.size() == 0 || acc_a[0] !== BOOT || iss_q[0] !== BOOT) begin
            n_err++; $display("FAIL rmid_restart: got %h want %h", (acc_a.size() > 0) ? acc_a[0] : 8'hxx, BOOT);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
            n_cmp++; if (mem_en_o !== e_en) begin n_err++; $display("FAIL rnd_en@%0d: got %b want %b", cyc_n, mem_en_o, e_en); end
            if (e_en) begin
                n_cmp++; if (mem_addr_o !== e_maddr) begin n_err++; $display("FAIL rnd_maddr@%0d: got %h want %h", cyc_n, mem_addr_o, e_maddr); end
            end
            n_cmp++; if (instr_valid_o !== e_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc_n, instr_valid_o, e_valid); end
            if (e_valid) begin
                n_cmp++;
                if (instr_addr_o !== e_addr || instr_rdata_o !== e_data) begin
                    n_err++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", cyc_n, instr_addr_o, instr_rdata_o, e_addr, e_data);
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1; req_i = 0; branch_i = 0; branch_addr_i = '0; instr_ready_i = 0;
        model_reset();
        clear_log();
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_flush();
        test_wrap();
        test_branch_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
